stepper_axis_driver: RTL and testbench

STEPPER_AXIS_DRIVER -- requirements
Module: stepper_axis_driver

---
 rtl/stepper_axis_driver.sv | 168 ++++++++++++++++
 tb/tb_stepper_axis_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/stepper_axis_driver.sv
// Single-axis full-step stepper driver: direction FSM, step prescaler,
// reversal settle window, quadrature phase sequencing and a wrapping
// position counter.
module stepper_axis_driver #(
  parameter int DIV     = 50000,  // clock cycles per motor step
  parameter int DEAD    = 1000,   // settle cycles on direction reversal
  parameter int POS_MOD = 360     // position wrap modulus in steps
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  dir,
  input  logic        pos_load,
  input  logic [15:0] pos_in,
  output logic [3:0]  coils,
  output logic [15:0] pos,
  output logic        step_pulse,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b01;

  localparam int PW = $clog2(DIV);
  localparam int SW = (DEAD > 1) ? $clog2(DEAD) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(DEAD - 1);
  localparam logic [15:0]   POS_MAX    = 16'(POS_MOD - 1);

  logic [1:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_settle;
  logic [1:0]    r_dir_q;
  logic [1:0]    r_phase;
  logic [15:0]   r_pos;
  logic [3:0]    r_coils;
  logic          r_step;
  logic          r_busy;

  logic [1:0]    w_state_next;
  logic [PW-1:0] w_presc_next;
  logic [SW-1:0] w_settle_next;
  logic [1:0]    w_dir_q_next;
  logic          w_step;
  logic          w_dir_valid;
  logic [1:0]    w_phase_next;
  logic [15:0]   w_pos_next;
  logic [3:0]    w_coils_next;
  logic          w_load_ok;

  // Full-step, two-phase-on drive pattern for each phase index
  function automatic logic [3:0] phase_pattern(input logic [1:0] ph);
    case (ph)
      2'd0:    phase_pattern = 4'b1100;
      2'd1:    phase_pattern = 4'b0110;
      2'd2:    phase_pattern = 4'b0011;
      default: phase_pattern = 4'b1001;
    endcase
  endfunction

  assign w_dir_valid = (dir == DIR_UP) || (dir == DIR_DOWN);
  assign w_load_ok   = pos_load && (pos_in <= POS_MAX);

  // FSM next-state, prescaler and settle counter; decides when a step fires
  always_comb begin
    w_state_next  = r_state;
    w_presc_next  = r_presc;
    w_settle_next = r_settle;
    w_dir_q_next  = r_dir_q;
    w_step        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_presc_next  = '0;
        w_settle_next = '0;
        if (en && w_dir_valid) begin
          w_state_next = S_RUN;
          w_dir_q_next = dir;
        end
      end
      S_RUN: begin
        if (!en || !w_dir_valid) begin
          w_state_next = S_IDLE;
          w_presc_next = '0;
        end else if (dir != r_dir_q) begin
          // dir_q is always a valid direction here, so any other valid
          // command is a reversal and must go through the settle window
          w_state_next  = S_SETTLE;
          w_presc_next  = '0;
          w_settle_next = '0;
        end else if (r_presc == PRESC_MAX) begin
          w_step       = 1'b1;
          w_presc_next = '0;
        end else begin
          w_presc_next = r_presc + 1'b1;
        end
      end
      S_SETTLE: begin
        w_presc_next = '0;
        if (!en || (r_settle == SETTLE_MAX)) begin
          w_state_next  = S_IDLE;
          w_settle_next = '0;
        end else begin
          w_settle_next = r_settle + 1'b1;
        end
      end
      default: begin
        w_state_next  = S_IDLE;
        w_presc_next  = '0;
        w_settle_next = '0;
      end
    endcase
  end

  // Phase index, position counter (calibration load wins over a step) and coil drive
  always_comb begin
    w_phase_next = r_phase;
    w_pos_next   = r_pos;
    if (w_step) begin
      if (r_dir_q == DIR_UP) begin
        w_phase_next = r_phase + 2'd1;
        w_pos_next   = (r_pos >= POS_MAX) ? 16'd0 : r_pos + 16'd1;
      end else begin
        w_phase_next = r_phase - 2'd1;
        w_pos_next   = (r_pos == 16'd0) ? POS_MAX : r_pos - 16'd1;
      end
    end
    if (w_load_ok) begin
      w_pos_next = pos_in;
    end
    w_coils_next = en ? phase_pattern(w_phase_next) : 4'b0000;
  end

  // State and output registers; reset aborts motion immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_settle <= '0;
      r_dir_q  <= 2'b00;
      r_phase  <= 2'd0;
      r_pos    <= 16'd0;
      r_coils  <= 4'b0000;
      r_step   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_presc  <= w_presc_next;
      r_settle <= w_settle_next;
      r_dir_q  <= w_dir_q_next;
      r_phase  <= w_phase_next;
      r_pos    <= w_pos_next;
      r_coils  <= w_coils_next;
      r_step   <= w_step;
      r_busy   <= (w_state_next != S_IDLE);
    end
  end

  assign coils      = r_coils;
  assign pos        = r_pos;
  assign step_pulse = r_step;
  assign busy       = r_busy;

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Directed bench for stepper_axis_driver with DIV=4, DEAD=3, POS_MOD=360.
module tb_stepper_axis_driver;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  dir;
  logic        pos_load;
  logic [15:0] pos_in;
  logic [3:0]  coils;
  logic [15:0] pos;
  logic        step_pulse;
  logic        busy;

  stepper_axis_driver #(.DIV(4), .DEAD(3), .POS_MOD(360)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dir        (dir),
    .pos_load   (pos_load),
    .pos_in     (pos_in),
    .coils      (coils),
    .pos        (pos),
    .step_pulse (step_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  dir;
    logic        ld;
    logic [15:0] pin;
    logic [3:0]  coils;
    logic [15:0] pos;
    logic        step;
    logic        busy;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic addn(input int n, input logic e, input logic [1:0] d,
                      input logic l, input logic [15:0] pi,
                      input logic [3:0] c, input logic [15:0] p,
                      input logic s, input logic b);
    for (int k = 0; k < n; k++) begin
      vecs[nv].en    = e;
      vecs[nv].dir   = d;
      vecs[nv].ld    = l;
      vecs[nv].pin   = pi;
      vecs[nv].coils = c;
      vecs[nv].pos   = p;
      vecs[nv].step  = s;
      vecs[nv].busy  = b;
      nv++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic [15:0] p,
                         input logic s, input logic b);
    chk({tag, ".coils"}, int'(coils), int'(c));
    chk({tag, ".pos"}, int'(pos), int'(p));
    chk({tag, ".step"}, int'(step_pulse), int'(s));
    chk({tag, ".busy"}, int'(busy), int'(b));
  endtask

  initial begin
    // en, dir, load, pos_in -> coils, pos, step, busy (one row per clock)
    addn(4, 1, 2'b10, 0, 0,   4'b1100, 0,   0, 1);  // enter RUN, prescale
    addn(1, 1, 2'b10, 0, 0,   4'b0110, 1,   1, 1);  // step 1 at cycle 5
    addn(3, 1, 2'b10, 0, 0,   4'b0110, 1,   0, 1);
    addn(1, 1, 2'b10, 0, 0,   4'b0011, 2,   1, 1);  // cycle 9
    addn(3, 1, 2'b10, 0, 0,   4'b0011, 2,   0, 1);
    addn(1, 1, 2'b10, 0, 0,   4'b1001, 3,   1, 1);  // cycle 13
    addn(3, 1, 2'b01, 0, 0,   4'b1001, 3,   0, 1);  // reversal -> SETTLE x3
    addn(1, 1, 2'b01, 0, 0,   4'b1001, 3,   0, 0);  // IDLE
    addn(4, 1, 2'b01, 0, 0,   4'b1001, 3,   0, 1);  // RUN down
    addn(1, 1, 2'b01, 0, 0,   4'b0011, 2,   1, 1);  // first down step
    addn(1, 0, 2'b01, 0, 0,   4'b0000, 2,   0, 0);  // en=0 halts
    addn(1, 0, 2'b01, 1, 400, 4'b0000, 2,   0, 0);  // out-of-range load ignored
    addn(1, 0, 2'b00, 1, 359, 4'b0000, 359, 0, 0);  // calibration load
    addn(4, 1, 2'b10, 0, 0,   4'b0011, 359, 0, 1);
    addn(1, 1, 2'b10, 0, 0,   4'b1001, 0,   1, 1);  // 359 -> 0 wrap
    addn(3, 1, 2'b10, 0, 0,   4'b1001, 0,   0, 1);
    addn(1, 1, 2'b10, 0, 0,   4'b1100, 1,   1, 1);  // phase back to 0
    addn(1, 1, 2'b00, 1, 0,   4'b1100, 0,   0, 0);  // stop + load 0
    addn(4, 1, 2'b01, 0, 0,   4'b1100, 0,   0, 1);
    addn(1, 1, 2'b01, 0, 0,   4'b1001, 359, 1, 1);  // 0 -> 359, phase 0 -> 3
    addn(3, 1, 2'b01, 0, 0,   4'b1001, 359, 0, 1);
    addn(1, 1, 2'b01, 1, 100, 4'b0011, 100, 1, 1);  // load beats coincident step
    addn(1, 1, 2'b10, 0, 0,   4'b0011, 100, 0, 1);  // reversal -> SETTLE
    addn(1, 0, 2'b10, 0, 0,   4'b0000, 100, 0, 0);  // en=0 in SETTLE -> IDLE
    addn(3, 1, 2'b10, 0, 0,   4'b0011, 100, 0, 1);  // RUN, prescaler reaches 2

    en = 0; dir = 2'b00; pos_load = 0; pos_in = 0;
    rst = 1'b1;
    tick();
    tick();
    chk_all("reset", 4'b0000, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < nv; i++) begin
      en       = vecs[i].en;
      dir      = vecs[i].dir;
      pos_load = vecs[i].ld;
      pos_in   = vecs[i].pin;
      tick();
      $display("vec %0d: en=%0b dir=%b ld=%0b pin=%0d -> coils=%b pos=%0d step=%0b busy=%0b",
               i + 1, en, dir, pos_load, pos_in, coils, pos, step_pulse, busy);
      chk($sformatf("vec%0d.coils", i + 1), int'(coils), int'(vecs[i].coils));
      chk($sformatf("vec%0d.pos", i + 1), int'(pos), int'(vecs[i].pos));
      chk($sformatf("vec%0d.step", i + 1), int'(step_pulse), int'(vecs[i].step));
      chk($sformatf("vec%0d.busy", i + 1), int'(busy), int'(vecs[i].busy));
    end
    pos_load = 0;

    // Asynchronous reset mid-RUN with the prescaler at 2 (a step was due in 2 cycles)
    #2 rst = 1'b1;
    #1;
    $display("async rst: coils=%b pos=%0d step=%0b busy=%0b", coils, pos, step_pulse, busy);
    chk_all("async_rst", 4'b0000, 16'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      $display("rst hold %0d: coils=%b pos=%0d step=%0b busy=%0b", k, coils, pos, step_pulse, busy);
      chk_all($sformatf("rst_hold%0d", k), 4'b0000, 16'd0, 1'b0, 1'b0);
    end
    dir = 2'b00;
    en  = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("post rst %0d: coils=%b pos=%0d step=%0b busy=%0b", k, coils, pos, step_pulse, busy);
      chk_all($sformatf("post_rst%0d", k), 4'b1100, 16'd0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
